// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/interlock controller in front of the multiply/divide
// unit. Latches operands of an accepted MD op, drives a one-cycle control
// code, holds the pipeline while the op is in flight, and serves MFHI/MFLO
// once the unit is idle.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,     // active-low, asynchronous
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [3:0]  md_ctrl,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic        mf_valid,
  output logic        div0
);
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_NONE  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] d1_q, d1_d;
  logic [31:0] d2_q, d2_d;

  logic accept, is_div_q, is_mf;

  // Only MD-class ops (MULT..MTLO) are consumed, and only from IDLE.
  assign accept   = e_valid && (e_op <= OP_MTLO) && (state_q == S_IDLE);
  assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_mf    = (e_op == OP_MFHI) || (e_op == OP_MFLO);

  // State, counter and operand registers; reset drops everything back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_NONE;
      d1_q    <= 32'd0;
      d2_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  // Next-state: ISSUE lasts one cycle, WAIT runs the latency down and then
  // additionally waits out the unit's own Busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          d1_d    = e_rs;
          d2_d    = e_rt;
          op_d    = e_op;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_MULT, OP_MULTU: begin
            cnt_d   = 4'(MUL_LAT);
            state_d = S_WAIT;
          end
          OP_DIV, OP_DIVU: begin
            cnt_d   = 4'(DIV_LAT);
            state_d = S_WAIT;
          end
          default: state_d = S_IDLE;  // MTHI/MTLO complete at issue
        endcase
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (!md_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: control code only during ISSUE; MF reads only when idle and
  // out of reset (inputs may be live while reset is held).
  always_comb begin
    md_ctrl  = (state_q == S_ISSUE) ? op_q : OP_NONE;
    div0     = (state_q == S_ISSUE) && is_div_q && (d2_q == 32'd0);
    stall    = e_valid && (e_op <= OP_MFLO) && (state_q != S_IDLE);
    mf_valid = reset && e_valid && is_mf && (state_q == S_IDLE);
    mf_data  = 32'd0;
    if (mf_valid) mf_data = (e_op == OP_MFHI) ? md_hi : md_lo;
  end

  assign md_d1 = d1_q;
  assign md_d2 = d2_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: reset values, MULT/DIVU/DIV/MTLO issue,
// stall lengths, Busy extension, and reset in the middle of a DIV.
module tb_md_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_rs, e_rt;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic [3:0]  md_ctrl;
  logic [31:0] md_d1, md_d2, mf_data;
  logic        stall, mf_valid, div0;

  int total = 0;
  int bad   = 0;
  int n;
  int nctl;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op),
    .e_rs(e_rs), .e_rt(e_rt), .md_busy(md_busy), .md_hi(md_hi),
    .md_lo(md_lo), .md_ctrl(md_ctrl), .md_d1(md_d1), .md_d2(md_d2),
    .stall(stall), .mf_data(mf_data), .mf_valid(mf_valid), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive stalled cycles (bounded) and how many of them showed an
  // active control code.
  task automatic count_stall(input int limit, output int cyc, output int ctl);
    cyc = 0;
    ctl = 0;
    while (stall && cyc < limit) begin
      cyc++;
      if (md_ctrl != 4'd15) ctl++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_op = 4'd15; e_rs = '0; e_rt = '0;
    md_busy = 1'b0; md_hi = '0; md_lo = '0;
    #1 reset = 1'b0;

    // 1. reset with random inputs
    for (int i = 0; i < 3; i++) begin
      e_valid = 1'b1;
      e_op    = 4'($urandom_range(0, 15));
      e_rs    = $urandom; e_rt = $urandom;
      md_hi   = $urandom; md_lo = $urandom;
      md_busy = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_md_ctrl", 32'(md_ctrl), 32'd15);
    chk("rst_md_d1", md_d1, 32'd0);
    chk("rst_md_d2", md_d2, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mf_valid", 32'(mf_valid), 32'd0);
    chk("rst_mf_data", mf_data, 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    reset = 1'b1; md_busy = 1'b0;
    e_valid = 1'b1; e_op = 4'd6; md_hi = 32'h1234; md_lo = 32'd42;
    #1;
    chk("mfhi_data", mf_data, 32'h1234);
    chk("mfhi_valid", 32'(mf_valid), 32'd1);
    chk("mfhi_stall", 32'(stall), 32'd0);
    step();

    // 2. MULT 7*6, then MFLO stalls 7 cycles
    e_op = 4'd0; e_rs = 32'd7; e_rt = 32'd6;
    #1 chk("mult_acc_stall", 32'(stall), 32'd0);
    step();
    e_op = 4'd7;
    #1;
    chk("mult_ctrl", 32'(md_ctrl), 32'd0);
    chk("mult_d1", md_d1, 32'd7);
    chk("mult_d2", md_d2, 32'd6);
    count_stall(30, n, nctl);
    chk("mult_stall_cyc", 32'(n), 32'd7);
    chk("mult_ctrl_cyc", 32'(nctl), 32'd1);
    chk("mflo_valid", 32'(mf_valid), 32'd1);
    chk("mflo_data", mf_data, 32'd42);
    step();

    // 3. DIVU 100/0 flags div0; following DIV stalls 12 cycles then issues
    e_op = 4'd3; e_rs = 32'd100; e_rt = 32'd0;
    step();
    e_op = 4'd1; e_rs = 32'd9; e_rt = 32'd5;
    #1;
    chk("divu_div0", 32'(div0), 32'd1);
    chk("divu_ctrl", 32'(md_ctrl), 32'd3);
    count_stall(30, n, nctl);
    chk("divu_stall_cyc", 32'(n), 32'd12);
    step();
    e_valid = 1'b0;
    chk("div_ctrl", 32'(md_ctrl), 32'd1);
    chk("div_d1", md_d1, 32'd9);
    chk("div_div0", 32'(div0), 32'd0);
    for (int i = 0; i < 12; i++) step();

    // 4. MTLO then back-to-back MFLO: one stall cycle
    e_valid = 1'b1; e_op = 4'd5; e_rs = 32'hDEADBEEF;
    step();
    e_op = 4'd7; md_lo = 32'h55AA;
    #1;
    chk("mtlo_ctrl", 32'(md_ctrl), 32'd5);
    chk("mtlo_d1", md_d1, 32'hDEADBEEF);
    count_stall(30, n, nctl);
    chk("mtlo_stall_cyc", 32'(n), 32'd1);
    chk("mtlo_mflo_valid", 32'(mf_valid), 32'd1);
    chk("mtlo_mflo_data", mf_data, 32'h55AA);
    step();

    // 5. MULT with Busy held 3 cycles past cnt==0: 10 stall cycles
    e_op = 4'd2; e_rs = 32'd3; e_rt = 32'd3;
    step();
    e_op = 4'd6; md_hi = 32'h77;
    #1;
    n = 0;
    while (stall && n < 30) begin
      n++;
      md_busy = (n <= 9);
      step();
    end
    md_busy = 1'b0;
    chk("busy_stall_cyc", 32'(n), 32'd10);
    chk("busy_mfhi_data", mf_data, 32'h77);
    step();

    // 6. reset 4 cycles into a DIV's WAIT
    e_op = 4'd1; e_rs = 32'd50; e_rt = 32'd2;
    step();                                   // ISSUE
    e_op = 4'd0; e_rs = 32'd3; e_rt = 32'd4;
    for (int i = 0; i < 5; i++) step();       // 4 cycles into WAIT
    chk("mid_div_stall", 32'(stall), 32'd1);
    e_op = 4'd15;
    #1 chk("none_no_stall", 32'(stall), 32'd0);
    e_op = 4'd0;
    reset = 1'b0;
    #1;
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_ctrl", 32'(md_ctrl), 32'd15);
    chk("rstmid_d1", md_d1, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_ctrl", 32'(md_ctrl), 32'd0);
    chk("post_rst_d1", md_d1, 32'd3);
    chk("post_rst_d2", md_d2, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
